health_sensor_scheduler: RTL
============================

Name: health_sensor_scheduler

Overview:
- Periodic round-robin sequencer for the shared HealthcareSystemPhase1 evaluation datapath.
- On each sample tick it visits the four sensor channels in order: pressure, blood chemistry, glucose, temperature.
- For each channel with valid data it accepts the sample, holds it on the datapath inputs, waits for the datapath to settle, then commits that channel's result flags.
- Consecutive abnormal results are filtered by persistence counters before any alarm is raised; the top-level monitor instantiates this block beside the datapath.

Parameters:
PERIOD, 32, sample-tick period in clk cycles (>=2)
EVAL_LAT, 2, cycles the datapath inputs are held before results are sampled (>=1)
PERSIST, 3, consecutive abnormal evaluations required to assert an alarm (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
enable  input  1  allows sample ticks
chanValid  input  4  per-channel sample available: [0] pressure, [1] blood, [2] glucose, [3] temperature
chanReady  output  1x4  one-cycle accept pulse per channel
pressureIn  input  6  pressure sample
bloodPHIn  input  4  blood pH sample
bloodTypeIn  input  3  blood type sample
bloodSensorIn  input  8  glucose sensor sample
tempIn  input  4  temperature sensor sample
dpPressureData  output  6  registered datapath input
dpBloodPH  output  4  registered datapath input
dpBloodType  output  3  registered datapath input
dpBloodSensor  output  8  registered datapath input
dpTempSensorValue  output  4  registered datapath input
dpPresureAbn  input  1  datapath pressure flag
dpBloodAbn  input  1  datapath blood flag
dpGlycemicIndex  input  4  datapath glycemic index
dpLowTempAbn  input  1  datapath low-temperature flag
dpHighTempAbn  input  1  datapath high-temperature flag
glycemicIndex  output  4  last committed glycemic index
pressureAlarm, bloodAlarm, lowTempAlarm, highTempAlarm  output  1 each  filtered alarms
roundDone  output  1  one-cycle pulse at the end of each round
overrun  output  1  sticky: a tick arrived while a round was still in progress
busy  output  1  FSM not IDLE

Behaviour:
- Fall-detection and factory-configuration datapath inputs are wired at the top level and are not scheduled here.
- Reset (synchronous, active-high):
  - All outputs, dp* registers, counters, the channel pointer and overrun clear to 0.
  - FSM goes to IDLE.
  - Reset mid-round aborts the round with no commit and no roundDone.
- Tick counter:
  - Counts 0..PERIOD-1 while enable=1, then wraps.
  - tick is asserted when the count equals PERIOD-1.
  - enable=0 holds the count at 0; any round already in progress still completes.
- FSM states: IDLE, SCAN, EVAL, COMMIT.
  - IDLE: on tick, set ptr=0 and go to SCAN.
  - SCAN with chanValid[ptr]=1:
    - Pulse chanReady[ptr] for this cycle.
    - Register that channel's inputs into its dp* outputs; other dp* registers hold.
    - Load waitCnt=EVAL_LAT and go to EVAL.
  - SCAN with chanValid[ptr]=0 (skip, costs 1 cycle): if ptr=3, go to IDLE and pulse roundDone; else ptr+1 and stay in SCAN.
  - EVAL: decrement waitCnt each cycle; after exactly EVAL_LAT EVAL cycles, go to COMMIT.
  - COMMIT: sample the dp flags for channel ptr.
    - ptr 0: pressure filter.
    - ptr 1: blood filter.
    - ptr 2: glycemicIndex <= dpGlycemicIndex.
    - ptr 3: low and high temperature filters.
    - Then, if ptr=3, go to IDLE and pulse roundDone; else ptr+1 and go to SCAN.
- Round length: 1 cycle per skipped channel, 2+EVAL_LAT cycles per accepted channel (default 4).
- Persistence filter, per flag:
  - 4-bit saturating counter; only updates on that channel's COMMIT.
  - Flag=1 increments up to PERSIST; flag=0 clears to 0.
  - Alarm = (count==PERSIST). Alarm is registered and updates in the cycle after COMMIT.
  - Channels skipped in a round leave their counters and alarms unchanged.
- Tick while not IDLE: the tick is dropped and overrun is set; overrun clears only on rst.
- chanValid changing during EVAL has no effect; the dp registers hold.

Optional Feature:
HEALTH_SCHED_ALARM_LATCH_EN:
- Defined:
  - Adds input alarmClear (1 bit).
  - Each alarm becomes sticky once asserted, and a normal result no longer clears it.
  - alarmClear=1 clears all alarms and persistence counters on the next edge; alarmClear wins over a simultaneous COMMIT.
- Undefined: no alarmClear port; alarms follow the persistence counters as described in Behaviour.

Test Plan:
- Reset check: rst held 3 cycles with all chanValid=1 -> all outputs 0, busy=0, no chanReady pulses.
- Full round (PERIOD=32, EVAL_LAT=2, chanValid=4'hF, datapath flags all 0) -> chanReady pulses for ch0..ch3 spaced 4 cycles apart; roundDone pulses 16 cycles after the first SCAN; overrun=0.
- Skip path: chanValid=4'b0101 -> only chanReady[0] and [2] pulse; round is 10 cycles; dpBloodPH and dpTempSensorValue keep their previous values.
- Persistence (PERSIST=3): dpPresureAbn=1 for rounds 1–3 -> pressureAlarm rises after the round-3 COMMIT; flag=0 in round 4 -> alarm drops after the round-4 COMMIT.
- Overrun: PERIOD=16, chanValid=4'hF (round = 16 cycles) -> second tick lands during the ch3 COMMIT; overrun=1 and stays 1; the next round starts only on the following tick.
- With HEALTH_SCHED_ALARM_LATCH_EN defined: lowTempAlarm asserted, then the flag returns to 0 -> alarm stays 1; alarmClear pulse -> alarm 0 on the next edge.

Source files
------------

// File: rtl/health_sensor_scheduler.sv
// Round-robin sample scheduler for the shared health evaluation datapath.
// On each sample tick it visits pressure, blood, glucose and temperature in
// order, holds the accepted sample on the dp* outputs for EVAL_LAT cycles,
// then commits that channel's flags through persistence filters.
// Ports: clk, rst (sync, active-high), enable, chanValid/chanReady handshake,
//   raw sensor inputs, dp* registered datapath inputs, dp flag inputs,
//   glycemicIndex, filtered alarms, roundDone, overrun (sticky), busy.
// Option: define HEALTH_SCHED_ALARM_LATCH_EN for sticky alarms plus an
//   alarmClear input that clears alarms and persistence counters.
module health_sensor_scheduler #(
    parameter int PERIOD   = 32,
    parameter int EVAL_LAT = 2,
    parameter int PERSIST  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
`ifdef HEALTH_SCHED_ALARM_LATCH_EN
    input  logic       alarmClear,
`endif
    input  logic [3:0] chanValid,
    output logic [3:0] chanReady,
    input  logic [5:0] pressureIn,
    input  logic [3:0] bloodPHIn,
    input  logic [2:0] bloodTypeIn,
    input  logic [7:0] bloodSensorIn,
    input  logic [3:0] tempIn,
    output logic [5:0] dpPressureData,
    output logic [3:0] dpBloodPH,
    output logic [2:0] dpBloodType,
    output logic [7:0] dpBloodSensor,
    output logic [3:0] dpTempSensorValue,
    input  logic       dpPresureAbn,
    input  logic       dpBloodAbn,
    input  logic [3:0] dpGlycemicIndex,
    input  logic       dpLowTempAbn,
    input  logic       dpHighTempAbn,
    output logic [3:0] glycemicIndex,
    output logic       pressureAlarm,
    output logic       bloodAlarm,
    output logic       lowTempAlarm,
    output logic       highTempAlarm,
    output logic       roundDone,
    output logic       overrun,
    output logic       busy
);
    localparam int TW = $clog2(PERIOD);
    localparam int WW = $clog2(EVAL_LAT + 1);
    localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
    localparam logic [WW-1:0] WLOAD = WW'(EVAL_LAT);
    localparam logic [WW-1:0] WONE  = WW'(1);
    localparam logic [3:0]    PMAX  = 4'(PERSIST);

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, COMMIT} state_t;

    state_t          state_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            tick;
    logic [1:0]      ptr_q;
    logic [WW-1:0]   wait_q;
    logic [5:0]      dp_p_q;
    logic [3:0]      dp_ph_q;
    logic [2:0]      dp_ty_q;
    logic [7:0]      dp_se_q;
    logic [3:0]      dp_te_q;
    logic [3:0]      gly_q;
    logic            done_q, ovr_q;
    // Filter index: 0 pressure, 1 blood, 2 low temp, 3 high temp
    logic [3:0]      pcnt_q [4];
    logic [3:0]      pcnt_d [4];
    logic [3:0]      alarm_q, alarm_d;
    logic [3:0]      flag, upd;

    assign tick = enable && (tcnt_q == TLAST);

    always_comb begin
        tcnt_d = tcnt_q + 1'b1;
        if (!enable || tcnt_q == TLAST) tcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end

    always_comb begin
        chanReady = '0;
        if (state_q == SCAN && chanValid[ptr_q]) chanReady[ptr_q] = 1'b1;
    end

    // Only the filters belonging to the committing channel move.
    always_comb begin
        flag = {dpHighTempAbn, dpLowTempAbn, dpBloodAbn, dpPresureAbn};
        upd  = '0;
        if (state_q == COMMIT) begin
            unique case (ptr_q)
                2'd0: upd = 4'b0001;
                2'd1: upd = 4'b0010;
                2'd2: upd = 4'b0000;
                2'd3: upd = 4'b1100;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            pcnt_d[i]  = pcnt_q[i];
            alarm_d[i] = alarm_q[i];
            if (upd[i]) begin
                if (!flag[i])             pcnt_d[i] = '0;
                else if (pcnt_q[i] < PMAX) pcnt_d[i] = pcnt_q[i] + 4'd1;
`ifdef HEALTH_SCHED_ALARM_LATCH_EN
                alarm_d[i] = alarm_q[i] | (pcnt_d[i] == PMAX);
`else
                alarm_d[i] = (pcnt_d[i] == PMAX);
`endif
            end
        end
`ifdef HEALTH_SCHED_ALARM_LATCH_EN
        if (alarmClear) begin
            for (int i = 0; i < 4; i++) pcnt_d[i] = '0;
            alarm_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wait_q  <= '0;
            dp_p_q  <= '0;
            dp_ph_q <= '0;
            dp_ty_q <= '0;
            dp_se_q <= '0;
            dp_te_q <= '0;
            gly_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            alarm_q <= '0;
            for (int i = 0; i < 4; i++) pcnt_q[i] <= '0;
        end else begin
            done_q  <= 1'b0;
            alarm_q <= alarm_d;
            for (int i = 0; i < 4; i++) pcnt_q[i] <= pcnt_d[i];
            // A tick during a round is dropped, only recorded.
            if (tick && state_q != IDLE) ovr_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        ptr_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (chanValid[ptr_q]) begin
                        unique case (ptr_q)
                            2'd0: dp_p_q <= pressureIn;
                            2'd1: begin
                                dp_ph_q <= bloodPHIn;
                                dp_ty_q <= bloodTypeIn;
                            end
                            2'd2: dp_se_q <= bloodSensorIn;
                            2'd3: dp_te_q <= tempIn;
                        endcase
                        wait_q  <= WLOAD;
                        state_q <= EVAL;
                    end else if (ptr_q == 2'd3) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 2'd1;
                    end
                end
                EVAL: begin
                    wait_q <= wait_q - 1'b1;
                    if (wait_q == WONE) state_q <= COMMIT;
                end
                COMMIT: begin
                    if (ptr_q == 2'd2) gly_q <= dpGlycemicIndex;
                    if (ptr_q == 2'd3) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_q + 2'd1;
                        state_q <= SCAN;
                    end
                end
            endcase
        end
    end

    assign dpPressureData    = dp_p_q;
    assign dpBloodPH         = dp_ph_q;
    assign dpBloodType       = dp_ty_q;
    assign dpBloodSensor     = dp_se_q;
    assign dpTempSensorValue = dp_te_q;
    assign glycemicIndex     = gly_q;
    assign pressureAlarm     = alarm_q[0];
    assign bloodAlarm        = alarm_q[1];
    assign lowTempAlarm      = alarm_q[2];
    assign highTempAlarm     = alarm_q[3];
    assign roundDone         = done_q;
    assign overrun           = ovr_q;
    assign busy              = (state_q != IDLE);

endmodule
